// File: rtl/usbf_csr_regs_pkg.sv
// Shared constants and decode helper for the PHY-domain CSR block.
// Holds register offsets, field masks, event indices and the offset decoder.
package usbf_csr_regs_pkg;

    localparam logic [7:0]  OFF_CTRL    = 8'h00;
    localparam logic [7:0]  OFF_STATUS  = 8'h04;
    localparam logic [7:0]  OFF_INT_STS = 8'h08;
    localparam logic [7:0]  OFF_INT_EN  = 8'h0C;
    localparam logic [2:0]  EP_REGION   = 3'b001;

    localparam logic [31:0] CTRL_MASK   = 32'h0000_7F03;
    localparam logic [15:0] EP_MASK     = 16'hFFE7;

    localparam int EVT_SOF     = 0;
    localparam int EVT_USB_RST = 1;
    localparam int EVT_SUSPEND = 2;
    localparam int EVT_RESUME  = 3;
    localparam int EVT_EP0     = 4;

    typedef enum logic [2:0] {
        SEL_NONE    = 3'd0,
        SEL_CTRL    = 3'd1,
        SEL_STATUS  = 3'd2,
        SEL_INT_STS = 3'd3,
        SEL_INT_EN  = 3'd4,
        SEL_EP      = 3'd5
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [2:0] ep;
    } dec_t;

    // EP slots at or beyond num_ep fall through to SEL_NONE and read as zero.
    function automatic dec_t decode_off(input logic [7:0] off, input logic [3:0] num_ep);
        dec_t d;
        d.ep  = off[4:2];
        d.sel = SEL_NONE;
        case (off)
            OFF_CTRL:    d.sel = SEL_CTRL;
            OFF_STATUS:  d.sel = SEL_STATUS;
            OFF_INT_STS: d.sel = SEL_INT_STS;
            OFF_INT_EN:  d.sel = SEL_INT_EN;
            default:     d.sel = ((off[7:5] == EP_REGION) && ({1'b0, off[4:2]} < num_ep))
                                 ? SEL_EP : SEL_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/usbf_csr_regs_if.sv
// Synchronised register-access bus between the AHB interface unit and the CSR file.
interface usbf_csr_regs_if;
    logic        sh2pt_wt_en_i;
    logic        sh2pt_rd_en_i;
    logic        sh2pd_enable_i;
    logic [31:0] sh2pd_addr_i;
    logic [31:0] sh2pd_wdata_i;
    logic [31:0] sp2hd_rdata_o;

    modport master (
        output sh2pt_wt_en_i, sh2pt_rd_en_i, sh2pd_enable_i, sh2pd_addr_i, sh2pd_wdata_i,
        input  sp2hd_rdata_o
    );

    modport slave (
        input  sh2pt_wt_en_i, sh2pt_rd_en_i, sh2pd_enable_i, sh2pd_addr_i, sh2pd_wdata_i,
        output sp2hd_rdata_o
    );
endinterface

// File: rtl/usbf_csr_regs_pulse_det.sv
// Rising-edge detector: turns a level strobe into a single-cycle pulse.
module usbf_csr_regs_pulse_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic lvl_i,
    output logic pulse_o
);
    logic lvl_q;

    // Previous level; cleared by reset so a level held through reset re-fires.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl_i;
        end
    end

    assign pulse_o = lvl_i & ~lvl_q;
endmodule

// File: rtl/usbf_csr_regs.sv
// PHY-clock-domain control/status register file: device control, interrupt
// status/enable and per-endpoint configuration, accessed over the synchronised bus.
module usbf_csr_regs
    import usbf_csr_regs_pkg::*;
#(
    parameter int NUM_EP   = 4,
    parameter int ADDR_LSB = 2
) (
    input  logic                   phy_clk_i,
    input  logic                   phy_rst_i,
    usbf_csr_regs_if.slave         bus,
    input  logic [7:0]             evt_i,
    input  logic [10:0]            frame_num_i,
    input  logic [1:0]             line_state_i,
    output logic                   dev_en_o,
    output logic                   soft_conn_o,
    output logic [6:0]             dev_addr_o,
    output logic [NUM_EP*16-1:0]   ep_cfg_o,
    output logic                   irq_o
);
    logic        wt_edge_s, rd_edge_s, wr_p_s, rd_p_s;
    logic [7:0]  off_s;
    dec_t        dec_s;
    logic [31:0] rd_val_s;
    logic [15:0] ep_rd_s;
    logic [7:0]  clr_s;

    logic [31:0] ctrl_q, ctrl_d;
    logic [7:0]  int_sts_q, int_sts_d;
    logic [7:0]  int_en_q, int_en_d;
    logic [15:0] ep_q [NUM_EP];
    logic [15:0] ep_d [NUM_EP];
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;
    logic        unused_addr_s;

    usbf_csr_regs_pulse_det u_wt_det (
        .clk_i   (phy_clk_i),
        .rst_i   (phy_rst_i),
        .lvl_i   (bus.sh2pt_wt_en_i),
        .pulse_o (wt_edge_s)
    );

    usbf_csr_regs_pulse_det u_rd_det (
        .clk_i   (phy_clk_i),
        .rst_i   (phy_rst_i),
        .lvl_i   (bus.sh2pt_rd_en_i),
        .pulse_o (rd_edge_s)
    );

    assign wr_p_s        = wt_edge_s & bus.sh2pd_enable_i;
    assign rd_p_s        = rd_edge_s & bus.sh2pd_enable_i;
    assign off_s         = {bus.sh2pd_addr_i[7:ADDR_LSB], {ADDR_LSB{1'b0}}};
    assign dec_s         = decode_off(off_s, 4'(NUM_EP));
    assign unused_addr_s = ^{bus.sh2pd_addr_i[31:8], bus.sh2pd_addr_i[ADDR_LSB-1:0]};

    // Next-state for writable registers and read-data mux (reads see pre-write state).
    always_comb begin
        ctrl_d   = ctrl_q;
        int_en_d = int_en_q;
        clr_s    = 8'h00;
        ep_rd_s  = 16'h0000;
        rd_val_s = 32'h0000_0000;
        if (wr_p_s) begin
            case (dec_s.sel)
                SEL_CTRL:    ctrl_d   = bus.sh2pd_wdata_i & CTRL_MASK;
                SEL_INT_STS: clr_s    = bus.sh2pd_wdata_i[7:0];
                SEL_INT_EN:  int_en_d = bus.sh2pd_wdata_i[7:0];
                default:     ctrl_d   = ctrl_q;
            endcase
        end else begin
            ctrl_d = ctrl_q;
        end
        for (int n = 0; n < NUM_EP; n++) begin
            ep_d[n] = (wr_p_s && (dec_s.sel == SEL_EP) && (dec_s.ep == 3'(n)))
                      ? (bus.sh2pd_wdata_i[15:0] & EP_MASK) : ep_q[n];
            ep_rd_s = ep_rd_s | ((dec_s.ep == 3'(n)) ? ep_q[n] : 16'h0000);
        end
        // Events are OR-ed in after the clear so a coincident event survives a W1C.
        int_sts_d = (int_sts_q & ~clr_s) | evt_i;
        irq_d     = |(int_sts_q & int_en_q);
        case (dec_s.sel)
            SEL_CTRL:    rd_val_s = ctrl_q;
            SEL_STATUS:  rd_val_s = {18'h0, line_state_i, 1'b0, frame_num_i};
            SEL_INT_STS: rd_val_s = {24'h0, int_sts_q};
            SEL_INT_EN:  rd_val_s = {24'h0, int_en_q};
            SEL_EP:      rd_val_s = {16'h0, ep_rd_s};
            default:     rd_val_s = 32'h0000_0000;
        endcase
        rdata_d = rd_p_s ? rd_val_s : rdata_q;
    end

    // Register state with synchronous reset.
    always_ff @(posedge phy_clk_i) begin
        if (phy_rst_i) begin
            ctrl_q    <= 32'h0000_0000;
            int_sts_q <= 8'h00;
            int_en_q  <= 8'h00;
            rdata_q   <= 32'h0000_0000;
            irq_q     <= 1'b0;
            for (int n = 0; n < NUM_EP; n++) begin
                ep_q[n] <= 16'h0000;
            end
        end else begin
            ctrl_q    <= ctrl_d;
            int_sts_q <= int_sts_d;
            int_en_q  <= int_en_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
            for (int n = 0; n < NUM_EP; n++) begin
                ep_q[n] <= ep_d[n];
            end
        end
    end

    for (genvar g = 0; g < NUM_EP; g++) begin : g_ep
        assign ep_cfg_o[16*g +: 16] = ep_q[g];
    end

    assign bus.sp2hd_rdata_o = rdata_q;
    assign dev_en_o          = ctrl_q[0];
    assign soft_conn_o       = ctrl_q[1];
    assign dev_addr_o        = ctrl_q[14:8];
    assign irq_o             = irq_q;
endmodule

// File: tb/tb_usbf_csr_regs.sv
// Self-checking bench for usbf_csr_regs: directed vector table plus randomized
// traffic compared against a register-map level reference model.
module tb_usbf_csr_regs;
    localparam int NUM_EP = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         evt;
    logic [10:0]        frame;
    logic [1:0]         ls;
    logic               dev_en, soft_conn, irq;
    logic [6:0]         dev_addr;
    logic [NUM_EP*16-1:0] ep_cfg;

    int errors = 0;
    int checks = 0;

    usbf_csr_regs_if bif ();

    usbf_csr_regs #(.NUM_EP(NUM_EP), .ADDR_LSB(2)) dut (
        .phy_clk_i    (clk),
        .phy_rst_i    (rst),
        .bus          (bif),
        .evt_i        (evt),
        .frame_num_i  (frame),
        .line_state_i (ls),
        .dev_en_o     (dev_en),
        .soft_conn_o  (soft_conn),
        .dev_addr_o   (dev_addr),
        .ep_cfg_o     (ep_cfg),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, wt, rd, en;
        logic [31:0] addr, wdata;
        logic [7:0]  evt;
        logic [31:0] exp_rdata;
        logic [8:0]  exp_ctrl;
        logic        exp_irq;
        logic [63:0] exp_ep;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: the architectural registers as the map describes them.
    logic [31:0] m_ctrl;
    logic [7:0]  m_sts, m_ie;
    logic [15:0] m_ep [8];
    logic [31:0] m_rdata;
    logic        m_irq, m_pwt, m_prd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic w, input logic rd, input logic en,
                       input logic [31:0] a, input logic [31:0] wd, input logic [7:0] e,
                       input logic [31:0] xr, input logic [8:0] xc, input logic xi,
                       input logic [63:0] xe);
        vec_t v;
        v.rst = r; v.wt = w; v.rd = rd; v.en = en; v.addr = a; v.wdata = wd; v.evt = e;
        v.exp_rdata = xr; v.exp_ctrl = xc; v.exp_irq = xi; v.exp_ep = xe;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic w, input logic rd, input logic en,
                         input logic [31:0] a, input logic [31:0] wd, input logic [7:0] e,
                         input logic [10:0] f, input logic [1:0] l);
        rst = r; bif.sh2pt_wt_en_i = w; bif.sh2pt_rd_en_i = rd; bif.sh2pd_enable_i = en;
        bif.sh2pd_addr_i = a; bif.sh2pd_wdata_i = wd; evt = e; frame = f; ls = l;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [10:0] f,
                                           input logic [1:0] l);
        int off = int'(a[7:0]) & 32'hFC;
        int n   = (off - 32'h20) / 4;
        if (off == 32'h00) return m_ctrl;
        if (off == 32'h04) return (32'(l) << 12) | 32'(f);
        if (off == 32'h08) return 32'(m_sts);
        if (off == 32'h0C) return 32'(m_ie);
        if (off >= 32'h20 && off <= 32'h3C && n < NUM_EP) return 32'(m_ep[n]);
        return 32'h0000_0000;
    endfunction

    task automatic m_step(input logic r, input logic w, input logic rd, input logic en,
                          input logic [31:0] a, input logic [31:0] wd, input logic [7:0] e,
                          input logic [10:0] f, input logic [1:0] l);
        bit          do_wr, do_rd;
        int          off, n;
        logic [31:0] rv;
        if (r) begin
            m_ctrl = 32'h0; m_sts = 8'h0; m_ie = 8'h0; m_rdata = 32'h0; m_irq = 1'b0;
            m_pwt = 1'b0; m_prd = 1'b0;
            for (int i = 0; i < 8; i++) m_ep[i] = 16'h0;
            return;
        end
        do_wr = w && !m_pwt && en;
        do_rd = rd && !m_prd && en;
        off   = int'(a[7:0]) & 32'hFC;
        n     = (off - 32'h20) / 4;
        rv    = m_read(a, f, l);
        m_irq = (m_sts & m_ie) != 8'h0;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) m_sts[i] = 1'b1;
            else if (do_wr && off == 32'h08 && wd[i]) m_sts[i] = 1'b0;
        end
        if (do_wr) begin
            if (off == 32'h00) m_ctrl = wd & 32'h0000_7F03;
            if (off == 32'h0C) m_ie = wd[7:0];
            if (off >= 32'h20 && off <= 32'h3C && n < NUM_EP) m_ep[n] = wd[15:0] & 16'hFFE7;
        end
        if (do_rd) m_rdata = rv;
        m_pwt = w;
        m_prd = rd;
    endtask

    initial begin
        logic [63:0] exp_ep;
        logic        w_l, r_l, rs, en_l;
        logic [31:0] a, wd;
        logic [7:0]  e;
        logic [10:0] f;
        logic [1:0]  l;
        logic [31:0] offs [14];

        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 8'h0, 11'h5A5, 2'd2);

        // Directed vectors: each row is one clock, expectations are post-edge values.
        //   rst   wt    rd    en    addr        wdata           evt    rdata           ctrl    irq   ep
        add(1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0,          9'h000, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0,          9'h000, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 32'h0000_2A03,  8'h00, 32'h0,          9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0,          9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0,          9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0,          9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h04, 32'h0,          8'h00, 32'h0000_25A5,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_25A5,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_25A5,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_2A03,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_2A03,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h0C, 32'h02,         8'h00, 32'h0000_2A03,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h02, 32'h0000_2A03,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_2A03,  9'h0AB, 1'b1, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h08, 32'h02,         8'h00, 32'h0000_2A03,  9'h0AB, 1'b1, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_2A03,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h01, 32'h0000_2A03,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h08, 32'h01,         8'h01, 32'h0000_2A03,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h08, 32'h0,          8'h00, 32'h0000_0001,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_0001,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h08, 32'h01,         8'h00, 32'h0000_0001,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h08, 32'h0,          8'h00, 32'h0,          9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0,          9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_2A03,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h3C, 32'hFFFF_FFFF,  8'h00, 32'h0000_2A03,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h3C, 32'h0,          8'h00, 32'h0,          9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h04, 32'hFFFF_FFFF,  8'h00, 32'h0,          9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h04, 32'h0,          8'h00, 32'h0000_25A5,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_25A5,  9'h0AB, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h24, 32'hFFFF_FFFF,  8'h00, 32'h0000_25A5,  9'h0AB, 1'b0, 64'h0000_0000_FFE7_0000);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h24, 32'h0,          8'h00, 32'h0000_FFE7,  9'h0AB, 1'b0, 64'h0000_0000_FFE7_0000);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h02,         8'h00, 32'h0000_FFE7,  9'h0AB, 1'b0, 64'h0000_0000_FFE7_0002);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0,          8'h00, 32'h0000_0002,  9'h0AB, 1'b0, 64'h0000_0000_FFE7_0002);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_0002,  9'h0AB, 1'b0, 64'h0000_0000_FFE7_0002);
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 32'h0000_1501,  8'h00, 32'h0000_2A03,  9'h055, 1'b0, 64'h0000_0000_FFE7_0002);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_2A03,  9'h055, 1'b0, 64'h0000_0000_FFE7_0002);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_1501,  9'h055, 1'b0, 64'h0000_0000_FFE7_0002);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_1501,  9'h055, 1'b0, 64'h0000_0000_FFE7_0002);
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 32'h0,          8'h00, 32'h0000_1501,  9'h055, 1'b0, 64'h0000_0000_FFE7_0002);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_1501,  9'h055, 1'b0, 64'h0000_0000_FFE7_0002);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0000_1501,  9'h055, 1'b0, 64'h0000_0000_FFE7_0002);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 32'h0000_2A03,  8'h00, 32'h0000_1501,  9'h0AB, 1'b0, 64'h0000_0000_FFE7_0002);
        add(1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 32'h0000_2A03,  8'h00, 32'h0,          9'h000, 1'b0, 64'h0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 32'h0000_2A03,  8'h00, 32'h0,          9'h000, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 32'h0000_0102,  8'h00, 32'h0,          9'h006, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 32'h0000_7F03,  8'h00, 32'h0,          9'h006, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,          8'h00, 32'h0,          9'h006, 1'b0, 64'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].wt, tbl[i].rd, tbl[i].en, tbl[i].addr, tbl[i].wdata,
                  tbl[i].evt, 11'h5A5, 2'd2);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rdata", i), 64'(bif.sp2hd_rdata_o), 64'(tbl[i].exp_rdata));
            check($sformatf("vec%0d_ctrl", i), 64'({dev_addr, soft_conn, dev_en}), 64'(tbl[i].exp_ctrl));
            check($sformatf("vec%0d_irq", i), 64'(irq), 64'(tbl[i].exp_irq));
            check($sformatf("vec%0d_ep", i), 64'(ep_cfg), tbl[i].exp_ep);
        end

        // Randomized traffic against the reference model.
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C, 32'h20, 32'h24,
                 32'h28, 32'h2C, 32'h30, 32'h3C, 32'h40, 32'hFC};
        w_l = 1'b0;
        r_l = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rs   = (c == 0) || ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) < 3) w_l = ~w_l;
            if ($urandom_range(0, 9) < 3) r_l = ~r_l;
            en_l = ($urandom_range(0, 7) != 0);
            a    = (32'($urandom) & 32'hFFFF_FF03) | offs[$urandom_range(0, 13)];
            wd   = 32'($urandom);
            e    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            f    = 11'($urandom);
            l    = 2'($urandom);
            drive(rs, w_l, r_l, en_l, a, wd, e, f, l);
            m_step(rs, w_l, r_l, en_l, a, wd, e, f, l);
            @(posedge clk);
            #1;
            exp_ep = 64'h0;
            for (int n = 0; n < NUM_EP; n++) exp_ep[16*n +: 16] = m_ep[n];
            check($sformatf("rnd%0d_rdata", c), 64'(bif.sp2hd_rdata_o), 64'(m_rdata));
            check($sformatf("rnd%0d_ctrl", c), 64'({dev_addr, soft_conn, dev_en}),
                  64'({m_ctrl[14:8], m_ctrl[1:0]}));
            check($sformatf("rnd%0d_irq", c), 64'(irq), 64'(m_irq));
            check($sformatf("rnd%0d_ep", c), 64'(ep_cfg), exp_ep);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
